match_req_scatter: RTL and testbench

Scatters one lazy-match request group (up to `LAZY_LEN` candidate positions, selected by a strobe) from a job PE onto the `NUM_MATCH_REQ_CH` match-request channels toward the match PEs. Each issued request is tagged with its slot index. At group acceptance the block emits the `req_group_fire`/`req_group_strb` pair that primes the downstream response synchroniser. It accepts no new group until that synchroniser has delivered the previous response group.

---
 rtl/match_req_scatter.sv | 144 ++++++++++++++
 tb/tb_match_req_scatter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/match_req_scatter.sv
// match_req_scatter: scatters one lazy-match request group onto C request
// channels (slot i -> channel i % C) and gates new groups on the response sync.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     group handshake from the job PE
//   in_strb, in_head_addr, in_history_addr   group payload (L slots)
//   req_group_fire/strb   primes the downstream response synchroniser
//   resp_group_fire       synchroniser consumed the response group
//   req_valid/req_ready   per-channel request handshake
//   req_tag, req_head_addr, req_history_addr  per-channel payload

`ifndef LAZY_LEN
`define LAZY_LEN 4
`endif
`ifndef LAZY_LEN_LOG2
`define LAZY_LEN_LOG2 2
`endif
`ifndef NUM_MATCH_REQ_CH
`define NUM_MATCH_REQ_CH 2
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

module match_req_scatter #(
  parameter int JOB_PE_IDX = 0,
  parameter int L          = `LAZY_LEN,
  parameter int C          = `NUM_MATCH_REQ_CH,
  parameter int TAG_BITS   = `LAZY_LEN_LOG2,
  parameter int AW         = `ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [L-1:0]          in_strb,
  input  logic [AW-1:0]         in_head_addr,
  input  logic [L*AW-1:0]       in_history_addr,
  output logic                  req_group_fire,
  output logic [L-1:0]          req_group_strb,
  input  logic                  resp_group_fire,
  output logic [C-1:0]          req_valid,
  input  logic [C-1:0]          req_ready,
  output logic [C*TAG_BITS-1:0] req_tag,
  output logic [C*AW-1:0]       req_head_addr,
  output logic [C*AW-1:0]       req_history_addr
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [L-1:0]      pending_q, pending_d;
  logic [AW-1:0]     head_q, head_d;
  logic [L*AW-1:0]   hist_q, hist_d;

  logic [C-1:0]      ch_hit;
  logic [TAG_BITS-1:0] ch_slot [C];

  // Lowest pending slot per channel: scan downward so the last hit wins.
  always_comb begin
    for (int j = 0; j < C; j++) begin
      ch_hit[j]  = 1'b0;
      ch_slot[j] = '0;
      for (int s = L - 1; s >= 0; s--) begin
        if ((s % C) == j && pending_q[s]) begin
          ch_hit[j]  = 1'b1;
          ch_slot[j] = TAG_BITS'(s);
        end
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    pending_d        = pending_q;
    head_d           = head_q;
    hist_d           = hist_q;
    in_ready         = rst_n && (state_q == IDLE);
    req_group_fire   = in_valid && in_ready;
    req_group_strb   = in_strb;
    req_valid        = '0;
    req_tag          = '0;
    req_head_addr    = '0;
    req_history_addr = '0;

    for (int j = 0; j < C; j++) begin
      req_valid[j] = rst_n && (state_q == ISSUE) && ch_hit[j];
      if (req_valid[j]) begin
        req_tag[j*TAG_BITS +: TAG_BITS] = ch_slot[j];
        req_head_addr[j*AW +: AW]       = head_q + AW'(ch_slot[j]);
        req_history_addr[j*AW +: AW]    =
          hist_q[int'(ch_slot[j])*AW +: AW];
        if (req_ready[j]) pending_d[ch_slot[j]] = 1'b0;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (req_group_fire) begin
          pending_d = in_strb;
          head_d    = in_head_addr;
          hist_d    = in_history_addr;
          state_d   = (in_strb != '0) ? ISSUE : WAIT_RESP;
        end
      end
      ISSUE: begin
        if (pending_d == '0) state_d = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (resp_group_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      head_q    <= '0;
      hist_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      head_q    <= head_d;
      hist_q    <= hist_d;
    end
  end

`ifndef SYNTHESIS
  // A response group outside WAIT_RESP is ignored by the FSM; flag it.
  always_ff @(posedge clk) begin
    if (rst_n && resp_group_fire && state_q != WAIT_RESP)
      $error("match_req_scatter[%0d]: resp_group_fire outside WAIT_RESP",
             JOB_PE_IDX);
  end
`endif

endmodule

// File: tb/tb_match_req_scatter.sv
// tb_match_req_scatter: directed test-plan scenarios plus random traffic,
// checked against a queue-based reference model of the scatter rules.

module tb_match_req_scatter;

  localparam int L  = 4;
  localparam int C  = 2;
  localparam int TB = 2;
  localparam int AW = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [L-1:0]      in_strb;
  logic [AW-1:0]     in_head_addr;
  logic [L*AW-1:0]   in_history_addr;
  logic              req_group_fire;
  logic [L-1:0]      req_group_strb;
  logic              resp_group_fire;
  logic [C-1:0]      req_valid;
  logic [C-1:0]      req_ready;
  logic [C*TB-1:0]   req_tag;
  logic [C*AW-1:0]   req_head_addr;
  logic [C*AW-1:0]   req_history_addr;

  match_req_scatter #(
    .JOB_PE_IDX(0), .L(L), .C(C), .TAG_BITS(TB), .AW(AW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_strb(in_strb),
    .in_head_addr(in_head_addr),
    .in_history_addr(in_history_addr),
    .req_group_fire(req_group_fire),
    .req_group_strb(req_group_strb),
    .resp_group_fire(resp_group_fire),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_tag(req_tag),
    .req_head_addr(req_head_addr),
    .req_history_addr(req_history_addr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int fires = 0;

  // Model: phase 0 idle, 1 issuing, 2 waiting for the response group.
  int            phase = 0;
  int            pend[$];
  logic [AW-1:0]   m_head;
  logic [L*AW-1:0] m_hist;

  localparam logic [L*AW-1:0] HIST = {16'h40, 16'h30, 16'h20, 16'h10};

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic [L-1:0] strb,
                      input logic [AW-1:0] head, input logic [L*AW-1:0] hist,
                      input logic [C-1:0] rdy, input logic resp,
                      input logic rs);
    logic   exp_rdy;
    logic   ev;
    int     sl;
    int     fs [C];
    int     nq[$];
    rst_n           = rs;
    in_valid        = v;
    in_strb         = strb;
    in_head_addr    = head;
    in_history_addr = hist;
    req_ready       = rdy;
    resp_group_fire = resp;
    @(negedge clk);
    exp_rdy = rs && phase == 0;
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    check("grp_fire", 64'(req_group_fire), 64'(v && exp_rdy));
    if (v && exp_rdy) check("grp_strb", 64'(req_group_strb), 64'(strb));
    for (int j = 0; j < C; j++) begin
      sl = -1;
      foreach (pend[k]) if (sl < 0 && pend[k] % C == j) sl = pend[k];
      ev = rs && phase == 1 && sl >= 0;
      fs[j] = (ev && rdy[j]) ? sl : -1;
      check($sformatf("valid%0d", j), 64'(req_valid[j]), 64'(ev));
      if (ev) begin
        check($sformatf("tag%0d", j), 64'(req_tag[j*TB +: TB]), 64'(sl));
        check($sformatf("head%0d", j), 64'(req_head_addr[j*AW +: AW]),
              64'(AW'(m_head + AW'(sl))));
        check($sformatf("hist%0d", j), 64'(req_history_addr[j*AW +: AW]),
              64'(m_hist[sl*AW +: AW]));
      end
      if (!rs) begin
        check($sformatf("rst_tag%0d", j), 64'(req_tag[j*TB +: TB]), 64'd0);
        check($sformatf("rst_head%0d", j), 64'(req_head_addr[j*AW +: AW]),
              64'd0);
        check($sformatf("rst_hist%0d", j),
              64'(req_history_addr[j*AW +: AW]), 64'd0);
      end
    end
    if (!rs) begin
      phase = 0;
      pend.delete();
    end else if (phase == 0) begin
      if (v) begin
        m_head = head;
        m_hist = hist;
        pend.delete();
        for (int s = 0; s < L; s++) if (strb[s]) pend.push_back(s);
        phase = (pend.size() > 0) ? 1 : 2;
      end
    end else if (phase == 1) begin
      foreach (pend[k]) begin
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < C; j++) if (fs[j] == pend[k]) hit = 1'b1;
        if (hit) fires++;
        else nq.push_back(pend[k]);
      end
      pend = nq;
      if (pend.size() == 0) phase = 2;
    end else if (resp) begin
      phase = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc(input logic [C-1:0] rdy, input logic resp);
    step(1'b0, '0, '0, '0, rdy, resp, 1'b1);
  endtask

  initial begin
    rst_n           = 1'b0;
    in_valid        = 1'b0;
    in_strb         = '0;
    in_head_addr    = '0;
    in_history_addr = '0;
    req_ready       = '0;
    resp_group_fire = 1'b0;
    @(posedge clk);
    #1;
    repeat (2) step(1'b1, 4'hf, 16'h100, HIST, 2'b11, 1'b0, 1'b0);

    // Full group, all ready.
    step(1'b1, 4'b1111, 16'h100, HIST, 2'b11, 1'b0, 1'b1);
    idle_cyc(2'b11, 1'b0);
    idle_cyc(2'b11, 1'b0);
    check("full_wait", 64'(phase), 64'd2);
    idle_cyc(2'b11, 1'b1);
    idle_cyc(2'b11, 1'b0);

    // Sparse group: only channel 1.
    step(1'b1, 4'b1010, 16'h200, HIST, 2'b11, 1'b0, 1'b1);
    idle_cyc(2'b11, 1'b0);
    idle_cyc(2'b11, 1'b0);
    idle_cyc(2'b11, 1'b1);

    // Backpressure on channel 0.
    step(1'b1, 4'b1111, 16'hfffe, HIST, 2'b10, 1'b0, 1'b1);
    repeat (3) idle_cyc(2'b10, 1'b0);
    idle_cyc(2'b11, 1'b0);
    idle_cyc(2'b11, 1'b0);
    idle_cyc(2'b11, 1'b1);

    // Empty group.
    step(1'b1, 4'b0000, 16'h300, HIST, 2'b11, 1'b0, 1'b1);
    idle_cyc(2'b11, 1'b0);
    idle_cyc(2'b11, 1'b0);
    idle_cyc(2'b11, 1'b1);
    idle_cyc(2'b11, 1'b0);

    // Back-to-back: second group held through WAIT_RESP.
    step(1'b1, 4'b0011, 16'h400, HIST, 2'b11, 1'b0, 1'b1);
    step(1'b1, 4'b1100, 16'h500, HIST, 2'b11, 1'b0, 1'b1);
    step(1'b1, 4'b1100, 16'h500, HIST, 2'b11, 1'b0, 1'b1);
    step(1'b1, 4'b1100, 16'h500, HIST, 2'b11, 1'b1, 1'b1);
    step(1'b1, 4'b1100, 16'h500, HIST, 2'b11, 1'b0, 1'b1);
    check("b2b_accept", 64'(phase), 64'd1);
    idle_cyc(2'b11, 1'b0);
    idle_cyc(2'b11, 1'b1);

    // Reset mid-issue after one of four requests.
    step(1'b1, 4'b1111, 16'h600, HIST, 2'b01, 1'b0, 1'b1);
    idle_cyc(2'b01, 1'b0);
    step(1'b0, '0, '0, '0, 2'b11, 1'b0, 1'b0);
    step(1'b0, '0, '0, '0, 2'b11, 1'b0, 1'b0);
    step(1'b1, 4'b1111, 16'h700, HIST, 2'b11, 1'b0, 1'b1);
    idle_cyc(2'b11, 1'b0);
    idle_cyc(2'b11, 1'b0);
    idle_cyc(2'b11, 1'b1);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      logic rs;
      logic rp;
      rs = ($urandom_range(0, 99) != 0);
      rp = (phase == 2) && ($urandom_range(0, 2) == 0);
      step(1'b1 & $urandom_range(0, 1), L'($urandom), AW'($urandom),
           {$urandom, $urandom}, C'($urandom), rp, rs);
    end
    check("fires_seen", 64'(fires > 500), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
